// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC main controller: opcode map, FSM states,
// ALU op classes, fault codes and the datapath control vector.
package cpu_pkg;

    localparam logic [3:0] OP_LW   = 4'h0;
    localparam logic [3:0] OP_SW   = 4'h1;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] ERR_HALT    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef struct packed {
        logic       jmp;
        logic       beq;
        logic       bne;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       dest_reg;
        logic       mem_to_reg;
        logic       reg_write;
        logic       ram_read;
        logic       mem_write;
    } ctrl_t;

    // ADD..SLT occupy the contiguous block 0010-1001.
    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= 4'h2) && (op <= 4'h9);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'hA) || (op == 4'hE);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bus between the main controller (master) and the datapath/RAM side (slave).
interface cpu_control_fsm_if #(parameter int CNT_W = 16);

    logic             run;
    logic [3:0]       opcode;
    logic             mem_ready;
    logic             ir_load;
    logic             pc_write;
    logic             jmp;
    logic             beq;
    logic             bne;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic             dest_reg;
    logic             mem_to_reg;
    logic             reg_write;
    logic             ram_read;
    logic             mem_write;
    logic             busy;
    logic             halted;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, mem_ready,
        output ir_load, pc_write, jmp, beq, bne, alu_op, alu_src, dest_reg,
               mem_to_reg, reg_write, ram_read, mem_write, busy, halted, err,
               err_code, retired
    );

    modport slave (
        output run, opcode, mem_ready,
        input  ir_load, pc_write, jmp, beq, bne, alu_op, alu_src, dest_reg,
               mem_to_reg, reg_write, ram_read, mem_write, busy, halted, err,
               err_code, retired
    );

endinterface

// File: rtl/cpu_main_decoder.sv
// Pure combinational decode of (state, latched opcode) into the datapath control vector.
// Outputs are zero outside EXEC/MEM/WB and never depend on the live opcode input.
module cpu_main_decoder
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op_q,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: assign every output a default first so no path through the block infers a latch.
        ctrl = '0;
        if (state inside {EXEC, MEM, WB}) begin
            if (is_rtype(op_q)) begin
                ctrl.alu_op   = ALUOP_FUNC;
                ctrl.dest_reg = 1'b1;
            end else begin
                case (op_q)
                    OP_LW, OP_SW: ctrl.alu_src = 1'b1;
                    OP_BEQ: begin
                        ctrl.beq    = 1'b1;
                        ctrl.alu_op = ALUOP_SUB;
                    end
                    OP_BNE: begin
                        ctrl.bne    = 1'b1;
                        ctrl.alu_op = ALUOP_SUB;
                    end
                    OP_JMP:  ctrl.jmp = 1'b1;
                    default: ;
                endcase
            end
        end
        if (state == MEM) begin
            ctrl.ram_read  = (op_q == OP_LW);
            ctrl.mem_write = (op_q == OP_SW);
        end
        if (state == WB) begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = (op_q == OP_LW);
        end
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/write-back,
// waits on a variable-latency RAM with a timeout, and counts retired instructions.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic                clk,
    input logic                reset_n,
    cpu_control_fsm_if.master  bus
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [3:0]         op_q;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   retired_q;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               pc_write;
    state_t             next_instr;
    ctrl_t              ctrl;

    cpu_main_decoder u_decoder (
        .state (state_q),
        .op_q  (op_q),
        .ctrl  (ctrl)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        code_d     = code_q;
        pc_write   = 1'b0;
        next_instr = bus.run ? FETCH : IDLE;
        tmo_d      = '0;
        case (state_q)
            IDLE:   if (bus.run) state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                // op_q is loaded on this same edge, so the branch looks at the live opcode.
                if (bus.opcode == OP_HALT) begin
                    state_d = HALT;
                    err_d   = 1'b0;
                    code_d  = ERR_HALT;
                end else if (is_illegal(bus.opcode)) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                    code_d  = ERR_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_rtype(op_q)) begin
                    state_d = WB;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = MEM;
                end else begin
                    pc_write = 1'b1;
                    state_d  = next_instr;
                end
            end
            MEM: begin
                if (bus.mem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_write = 1'b1;
                        state_d  = next_instr;
                    end else begin
                        state_d = WB;
                    end
                end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WB: begin
                pc_write = 1'b1;
                state_d  = next_instr;
            end
            HALT: begin
                if (!bus.run) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    code_d  = ERR_HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            tmo_q     <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_HALT;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            code_q  <= code_d;
            if (state_q == DECODE) op_q <= bus.opcode;
            if (pc_write) retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.ir_load    = (state_q == FETCH);
    assign bus.pc_write   = pc_write;
    assign bus.jmp        = ctrl.jmp;
    assign bus.beq        = ctrl.beq;
    assign bus.bne        = ctrl.bne;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.alu_src    = ctrl.alu_src;
    assign bus.dest_reg   = ctrl.dest_reg;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.ram_read   = ctrl.ram_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.busy       = (state_q != IDLE) && (state_q != HALT);
    assign bus.halted     = (state_q == HALT);
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm; outputs are sampled 1-2 time
// units after the rising edge, inputs are driven at the same offset.
module tb_cpu_control_fsm;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cpu_control_fsm_if #(.CNT_W(16)) bus ();

    cpu_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int mw_cycles;
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.opcode    = 4'h0;
        bus.mem_ready = 1'b0;
        tick(2);
        check("reset_busy", bus.busy, 0);
        check("reset_retired", bus.retired, 0);
        check("reset_outputs", {bus.ir_load, bus.pc_write, bus.reg_write, bus.ram_read,
                                bus.mem_write, bus.halted, bus.err, bus.err_code}, 0);
        reset_n = 1'b1;
        tick();
        check("idle_no_run", bus.busy, 0);

        // ADD stream with run held high.
        bus.opcode = 4'b0010;
        bus.run    = 1'b1;
        tick();  // cycle 1 FETCH
        check("add_ir_load", bus.ir_load, 1);
        check("add_fetch_pcw", bus.pc_write, 0);
        tick();  // DECODE
        check("add_decode_ctrl", {bus.ir_load, bus.alu_op, bus.dest_reg}, 0);
        tick();  // EXEC
        check("add_exec", {bus.alu_op, bus.dest_reg, bus.reg_write, bus.pc_write}, 5'b10_1_0_0);
        tick();  // cycle 4 WB
        check("add_wb", {bus.reg_write, bus.pc_write, bus.dest_reg, bus.alu_op}, 5'b1_1_1_10);
        check("add_wb_retired", bus.retired, 0);
        tick();  // cycle 5 FETCH
        check("add_refetch", {bus.ir_load, bus.reg_write, bus.pc_write}, 3'b100);
        check("add_retired1", bus.retired, 1);
        tick(8);  // cycle 13
        check("add_retired3", bus.retired, 3);
        tick(2);  // EXEC of 4th ADD
        bus.run = 1'b0;
        tick();  // WB still completes
        check("rundrop_wb", {bus.reg_write, bus.pc_write}, 2'b11);
        tick();
        check("rundrop_idle", {bus.busy, bus.ir_load}, 2'b00);
        check("rundrop_retired", bus.retired, 4);

        // LW with two wait cycles.
        bus.opcode = 4'b0000;
        bus.run    = 1'b1;
        tick(3);  // EXEC
        check("lw_exec", {bus.alu_src, bus.alu_op, bus.ram_read}, 4'b1_00_0);
        tick();
        check("lw_mem1", {bus.ram_read, bus.alu_src, bus.pc_write}, 3'b110);
        tick();
        check("lw_mem2", bus.ram_read, 1);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        check("lw_mem3_ready", {bus.ram_read, bus.pc_write, bus.mem_write}, 3'b100);
        tick();  // cycle 7 WB
        bus.mem_ready = 1'b0;
        bus.run       = 1'b0;
        #1;
        check("lw_wb", {bus.mem_to_reg, bus.reg_write, bus.pc_write, bus.ram_read, bus.dest_reg},
              5'b11100);
        tick();
        check("lw_idle_retired", {bus.busy, bus.retired}, {1'b0, 16'd5});

        // BEQ, JMP, BNE back to back.
        bus.opcode = 4'b1011;
        bus.run    = 1'b1;
        tick(3);  // cycle 3 EXEC
        check("beq_exec", {bus.pc_write, bus.beq, bus.bne, bus.jmp, bus.alu_op, bus.reg_write},
              7'b1_1_0_0_01_0);
        bus.opcode = 4'b1101;
        #1;
        check("beq_no_opcode_path", {bus.beq, bus.jmp, bus.alu_op}, 4'b1_0_01);
        tick(3);  // cycle 6 EXEC
        check("jmp_exec", {bus.pc_write, bus.jmp, bus.beq, bus.alu_op, bus.reg_write},
              6'b1_1_0_00_0);
        check("jmp_retired", bus.retired, 6);
        bus.opcode = 4'b1100;
        tick(3);
        check("bne_exec", {bus.pc_write, bus.bne, bus.alu_op, bus.reg_write}, 5'b1_1_01_0);
        bus.run = 1'b0;
        tick();
        check("branch_retired", bus.retired, 8);

        // SW with RAM never ready: timeout fault.
        bus.opcode = 4'b0001;
        bus.run    = 1'b1;
        tick(3);
        check("sw_exec", {bus.alu_src, bus.mem_write}, 2'b10);
        mw_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.mem_write && !bus.pc_write && bus.busy) mw_cycles++;
        end
        check("sw_mem_write_cycles", mw_cycles, 15);
        tick();
        check("sw_timeout_halt", {bus.halted, bus.err, bus.err_code, bus.busy, bus.mem_write},
              6'b1_1_10_0_0);
        check("sw_timeout_retired", bus.retired, 8);
        tick(2);
        check("halt_sticky_run", bus.halted, 1);
        bus.run = 1'b0;
        tick();
        check("halt_exit_clear", {bus.halted, bus.err, bus.err_code, bus.busy}, 0);

        // Illegal opcodes and HALT.
        bus.opcode = 4'b1110;
        bus.run    = 1'b1;
        tick(3);
        check("illegal_e", {bus.halted, bus.err, bus.err_code}, 4'b1_1_01);
        bus.run = 1'b0;
        tick();
        bus.opcode = 4'b1010;
        bus.run    = 1'b1;
        tick(3);
        check("illegal_a", {bus.halted, bus.err, bus.err_code}, 4'b1_1_01);
        bus.run = 1'b0;
        tick();
        bus.opcode = 4'b1111;
        bus.run    = 1'b1;
        tick(3);
        check("halt_instr", {bus.halted, bus.err, bus.err_code, bus.retired}, {4'b1_0_00, 16'd8});
        bus.run = 1'b0;
        tick();

        // Reset asserted during MEM of an LW.
        bus.opcode = 4'b0000;
        bus.run    = 1'b1;
        tick(4);
        check("pre_reset_mem", bus.ram_read, 1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_mem", {bus.busy, bus.ram_read, bus.pc_write, bus.alu_src, bus.ir_load,
                                bus.retired}, 0);
        bus.run = 1'b0;
        tick();
        check("reset_hold", {bus.busy, bus.ram_read, bus.retired}, 0);
        reset_n = 1'b1;
        tick();

        // SW with RAM already ready on MEM entry: zero wait, retire in MEM.
        bus.opcode    = 4'b0001;
        bus.mem_ready = 1'b1;
        bus.run       = 1'b1;
        tick(4);
        bus.run = 1'b0;
        #1;
        check("sw_fast_mem", {bus.mem_write, bus.pc_write, bus.reg_write}, 3'b110);
        tick();
        check("sw_fast_retired", {bus.busy, bus.retired}, {1'b0, 16'd1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle main controller for the 16-bit RISC datapath.
- Sequences fetch, decode, execute, memory and write-back for each instruction.
- Drives every datapath control strobe: PC update, jump/branch selects, ALU op class, ALU source, destination-register mux, memory-to-register mux, register write, RAM read/write.
- Handshakes with a variable-latency data RAM and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles MEM may wait for mem_ready before faulting.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- opcode  in  4  instr[15:12] from the instruction ROM.
- mem_ready  in  1  data RAM has completed the current access.
- ir_load  out  1  capture instruction/opcode this cycle.
- pc_write  out  1  one-cycle strobe; PC loads pc_next.
- jmp, beq, bne  out  1 each  PC source selects.
- alu_op  out  2  00 add (LW/SW/JMP), 01 subtract/compare (BEQ/BNE), 10 function from opcode.
- alu_src  out  1  1 = sign-extended immediate.
- dest_reg  out  1  1 = instr[5:3], 0 = instr[8:6].
- mem_to_reg  out  1  write-back source is RAM.
- reg_write  out  1  register file write enable.
- ram_read  out  1  RAM read request.
- mem_write  out  1  RAM write request.
- busy  out  1  state is not IDLE and not HALT.
- halted  out  1  state is HALT.
- err  out  1  HALT was entered by a fault.
- err_code  out  2  00 HALT instruction, 01 illegal opcode, 10 memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, reset_n=0):
  - state = IDLE; all outputs 0; retired = 0; op_q = 0; timeout counter = 0.
  - Reset asserted mid-instruction abandons it, with no partial strobe after the reset edge.
- Opcode map:
  - 0000 LW, 0001 SW.
  - 0010–1001 R-type (ADD, SUB, INV, LSL, LSR, AND, OR, SLT).
  - 1010 reserved/illegal; 1011 BEQ; 1100 BNE; 1101 JMP; 1110 illegal; 1111 HALT.
- State transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: ir_load=1 -> DECODE.
  - DECODE: op_q <= opcode; HALT -> HALT (err=0, code 00); illegal -> HALT (err=1, code 01); otherwise -> EXEC.
  - EXEC:
    - R-type -> WB.
    - LW/SW -> MEM.
    - BEQ/BNE/JMP: pc_write=1, with beq, bne or jmp =1; instruction retires -> next.
  - MEM:
    - ram_read (LW) or mem_write (SW) held until mem_ready=1.
    - On mem_ready: SW does pc_write and retires -> next; LW -> WB.
    - If MEM_TIMEOUT cycles elapse without mem_ready -> HALT (err=1, code 10); no pc_write.
  - WB: reg_write=1, pc_write=1; instruction retires -> next.
  - "next" = FETCH if run=1, else IDLE. run is ignored mid-instruction.
  - HALT: outputs quiescent; run=0 -> IDLE, which clears err/err_code. Leaving HALT requires run to toggle low.
- Control decode:
  - Derived only from state and op_q; no combinational path from opcode to outputs.
  - Held constant through EXEC, MEM and WB; 0 in IDLE, FETCH, DECODE and HALT.
  - alu_src=1 for LW/SW.
  - dest_reg=1 for R-type, 0 for LW.
  - mem_to_reg=1 only in LW WB.
- Latency per instruction:
  - Branch/JMP: 3 cycles.
  - R-type: 4 cycles.
  - SW: 4 + wait cycles.
  - LW: 5 + wait cycles.
  - "wait" = cycles in MEM before mem_ready, counting 0 if mem_ready is already high on MEM entry.
- Retired counter:
  - Increments in exactly the cycle pc_write=1; wraps at 2^CNT_W.
  - pc_write and reg_write are never asserted in the same cycle as ir_load.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams;
  - state enum typedef (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC);
  - err_code constants.
- One natural sub-module: cpu_main_decoder, a pure combinational op_q + state -> control-vector block. The FSM, timeout counter and retired counter stay in cpu_control_fsm.

Test Plan:
- ADD stream: run=1, opcode=0010 held -> ir_load at cycle 1, reg_write=pc_write=1 and dest_reg=1, alu_op=10 at cycle 4; retired=3 after 12 cycles.
- LW with 2-cycle wait: opcode=0000, mem_ready high on 3rd MEM cycle -> ram_read held for 3 cycles, alu_src=1; WB has mem_to_reg=1, reg_write=1; total 7 cycles.
- BEQ then JMP: opcodes 1011, 1101 -> pc_write with beq=1, alu_op=01 at cycle 3; then jmp=1, alu_op=00 at cycle 6; reg_write never asserted.
- SW timeout: opcode=0001, mem_ready=0 -> mem_write held 15 cycles, then halted=1, err=1, err_code=10, retired unchanged; run=0 -> IDLE with err=0.
- Illegal/HALT: opcode=1110 -> halted, err_code=01 after DECODE. Opcode=1111 -> halted, err=0, err_code=00.
- Run drop and reset mid-instruction:
  - run=0 asserted in EXEC of an R-type -> WB completes, then IDLE.
  - reset_n low during MEM -> immediate IDLE, all outputs 0, retired=0.
